// File: rtl/vec_regfile_sb.sv
// Vector register file with in-flight destination scoreboard, feeding ALU_vec.
// Ports: clk/rst, read ra1/ra2 -> rd1/rd2, reserve rsv_en/rsv_addr,
//        lane-masked writeback we/wa/wd/wmask, stall, pending.
module vec_regfile_sb #(
    parameter int NREGS  = 16,
    parameter int AW     = 4,
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int VW     = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic             use1,
    input  logic             use2,
    output logic [VW-1:0]    rd1,
    output logic [VW-1:0]    rd2,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [VW-1:0]    wd,
    input  logic [LANES-1:0] wmask,
    output logic             stall,
    output logic [NREGS-1:0] pending
);

    logic [VW-1:0]    regs_q [NREGS];
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic             wr1;
    logic             wr2;
    logic             hz1;
    logic             hz2;

    assign wr1 = we && (wa == ra1);
    assign wr2 = we && (wa == ra2);

    // Zero-latency read; same-cycle writeback lanes override stored data.
    always_comb begin
        rd1 = regs_q[ra1];
        rd2 = regs_q[ra2];
        for (int i = 0; i < LANES; i++) begin
            if (wr1 && wmask[i]) begin
                rd1[i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
            end
            if (wr2 && wmask[i]) begin
                rd2[i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
            end
        end
    end

    // A writeback landing this cycle resolves the hazard via the bypass,
    // even with a partial mask.
    assign hz1   = use1 && pending_q[ra1] && !wr1;
    assign hz2   = use2 && pending_q[ra2] && !wr2;
    assign stall = hz1 || hz2;

    // Clear first, then set: a new reservation supersedes a completing write.
    always_comb begin
        pending_d = pending_q;
        if (we) begin
            pending_d[wa] = 1'b0;
        end
        if (rsv_en && !stall) begin
            pending_d[rsv_addr] = 1'b1;
        end
    end

    assign pending = pending_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            for (int r = 0; r < NREGS; r++) begin
                for (int i = 0; i < LANES; i++) begin
                    if (we && (wa == AW'(r)) && wmask[i]) begin
                        regs_q[r][i*LANE_W +: LANE_W] <= wd[i*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

endmodule

// File: doc/vec_regfile_sb.md
Name: vec_regfile_sb

Overview:
- Vector register file with a scoreboard that sits directly upstream of the vector ALU (ALU_vec).
- Supplies the two 256-bit operands to the ALU `a`/`b` inputs and accepts lane-masked writeback of the ALU `result`.
- Tracks in-flight destination registers and raises a stall when an issuing instruction reads a register that is still pending.
- Same-cycle writeback is bypassed to the read ports, so operands are never stale.

Parameters:
- NREGS, 16, number of vector registers (power of two).
- AW, 4, register address width, log2(NREGS).
- LANES, 16, lanes per vector.
- LANE_W, 16, bits per lane.
- VW, 256, vector width, LANES*LANE_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- ra1  in  AW  read address, operand a.
- ra2  in  AW  read address, operand b.
- use1  in  1  issuing instruction reads ra1.
- use2  in  1  issuing instruction reads ra2.
- rd1  out  VW  operand a data (to ALU a).
- rd2  out  VW  operand b data (to ALU b).
- rsv_en  in  1  issuing instruction reserves destination rsv_addr.
- rsv_addr  in  AW  destination register being reserved.
- we  in  1  writeback enable.
- wa  in  AW  writeback address.
- wd  in  VW  writeback data (from ALU result).
- wmask  in  LANES  per-lane write enable; bit i covers wd[i*LANE_W +: LANE_W].
- stall  out  1  issue must hold; operands not yet valid.
- pending  out  NREGS  scoreboard state, bit r = register r awaiting writeback.

Behaviour:
- Reset (rst=1, asynchronous):
  - All registers are 0.
  - pending = 0.
  - rd1/rd2 therefore read 0.
  - stall = 0.
  - Reset released mid-operation discards all reservations.
- Write (on posedge clk, rst=0, we=1):
  - For each lane i with wmask[i]=1, reg[wa] lane i <= wd lane i.
  - Lanes with wmask[i]=0 are unchanged.
  - wmask=0 with we=1 writes nothing but still clears pending[wa].
- Read (combinational, zero-latency):
  - rd1 = reg[ra1], with this bypass: if we=1 and wa==ra1, each lane with wmask[i]=1 is taken from wd.
  - rd2 is identical using ra2.
  - ra1==ra2 is legal; both ports return the same data.
- Scoreboard (posedge clk):
  - Step 1: if we=1, clear pending[wa].
  - Step 2: if issue_ok=1 and rsv_en=1, set pending[rsv_addr]. issue_ok = !stall.
  - If both target the same register in the same cycle, the set wins: a new reservation supersedes the completing write.
  - rsv_en while stall=1 is ignored; pending is unchanged by it.
  - Reserving an already-pending register is legal; the bit stays 1 (no count, single outstanding write per register).
- Stall (combinational):
  - hz1 = use1 & pending[ra1] & !(we & wa==ra1).
  - hz2 = use2 & pending[ra2] & !(we & wa==ra2).
  - stall = hz1 | hz2.
  - A writeback arriving in the same cycle resolves the hazard through the bypass. A partial wmask still clears the hazard; the partial-write contract is the writer's responsibility.
  - use1=use2=0 never stalls.
- Writeback to a non-pending register is legal: data is written and pending stays 0.
- No X propagation: every output is defined from reset onward.

Test Plan:
- Reset then read: assert rst, release; ra1=3, ra2=15 -> rd1=rd2=0, stall=0, pending=16'h0000.
- Full write and lane-masked write:
  - we, wa=5, wd=256'h1234_5678_90AB_CDEF repeated, wmask=16'hFFFF.
  - Next cycle we, wa=5, wd=all 1s, wmask=16'h0001.
  - -> ra1=5 reads the pattern with lane 0 = 16'hFFFF, other lanes unchanged.
- Same-cycle bypass: reg[7]=0; we, wa=7, wd=256'h9876_5432_10FE_DCBA repeated, wmask=16'h00FF, ra2=7 in the same cycle -> rd2 lanes 0-7 = wd lanes, lanes 8-15 = 0 before the clock edge.
- Hazard stall and release:
  - rsv_en, rsv_addr=2 -> pending=16'h0004.
  - Next cycle use1=1, ra1=2 -> stall=1.
  - Then we, wa=2 in the same cycle as the read -> stall=0, rd1=wd, pending[2]=0 after the edge.
- Simultaneous clear and set: pending[4]=1; we, wa=4 plus rsv_en, rsv_addr=4, no stall -> pending[4] remains 1. A reservation attempted while stall=1 (rsv_addr=9) -> pending[9] stays 0.
- Async reset mid-operation: pending=16'h0104, reg[8] nonzero; pulse rst between clock edges -> pending=0, reg[8]=0, stall=0 immediately, without waiting for clk.
